// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM states, owner tag,
// request layout and the saturating starvation-counter helper.
package mem_port_arbiter_pkg;

   localparam int ADDR_WIDTH = 64;
   localparam int DATA_WIDTH = 128;
   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
   typedef enum logic {OWN_I, OWN_D} owner_e;

   typedef struct packed {
      logic                  wen;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [MASK_WIDTH-1:0] wmask;
   } mem_req_t;

   typedef logic [3:0] starve_cnt_t;

   function automatic starve_cnt_t starve_sat_inc(input starve_cnt_t c);
      return (c == '1) ? c : starve_cnt_t'(c + 1'b1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_starve.sv
// Grant selection between I and D: D wins unless the I side has already
// lost STARVE_LIMIT consecutive decisions while it was eligible.
module arb_prio_starve #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic idle_i,
   input  logic i_valid_i,
   input  logic d_valid_i,
   input  logic fence_flush_i,
   output logic grant_i_o,
   output logic grant_d_o
);
   import mem_port_arbiter_pkg::*;

   localparam starve_cnt_t LIMIT = starve_cnt_t'(STARVE_LIMIT);

   starve_cnt_t starve_q, starve_d;
   logic        i_elig;

   assign i_elig    = i_valid_i & ~fence_flush_i;
   assign grant_d_o = idle_i & d_valid_i & (~i_elig | (starve_q < LIMIT));
   assign grant_i_o = idle_i & i_elig & ~grant_d_o;

   always_comb begin
      starve_d = starve_q;
      if (grant_d_o && i_elig)
         starve_d = starve_sat_inc(starve_q);
      else if (grant_d_o || grant_i_o)
         starve_d = '0;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) starve_q <= '0;
      else         starve_q <= starve_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream cache-line port between Icache refill and Dcache
// refill/writeback; one transaction in flight, I fetches droppable on fence.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 64,
   parameter int DATA_WIDTH   = 128,
   parameter int MASK_WIDTH   = DATA_WIDTH / 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  fence_flush,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  i_req_ready,
   output logic                  i_resp_valid,
   output logic [DATA_WIDTH-1:0] i_resp_data,
   input  logic                  d_req_valid,
   input  logic                  d_req_wen,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   input  logic [DATA_WIDTH-1:0] d_req_wdata,
   input  logic [MASK_WIDTH-1:0] d_req_wmask,
   output logic                  d_req_ready,
   output logic                  d_resp_valid,
   output logic [DATA_WIDTH-1:0] d_resp_data,
   output logic                  m_req_valid,
   input  logic                  m_req_ready,
   output logic                  m_req_wen,
   output logic [ADDR_WIDTH-1:0] m_req_addr,
   output logic [DATA_WIDTH-1:0] m_req_wdata,
   output logic [MASK_WIDTH-1:0] m_req_wmask,
   input  logic                  m_resp_valid,
   input  logic [DATA_WIDTH-1:0] m_resp_data
);
   import mem_port_arbiter_pkg::*;

   arb_state_e            state_q, state_d;
   owner_e                owner_q, owner_d;
   logic                  drop_q, drop_d;
   logic                  wen_q, wen_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
   logic                  idle, grant_i, grant_d, resp_hit, flush_own;

   // Grants are gated by rstn so the ready pulses are also silent in reset.
   assign idle      = rstn & (state_q == IDLE);
   assign resp_hit  = (state_q == WAIT) & m_resp_valid;
   assign flush_own = fence_flush & (owner_q == OWN_I);

   arb_prio_starve #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_prio (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .idle_i       (idle),
      .i_valid_i    (i_req_valid),
      .d_valid_i    (d_req_valid),
      .fence_flush_i(fence_flush),
      .grant_i_o    (grant_i),
      .grant_d_o    (grant_d)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         owner_q <= OWN_D;
         drop_q  <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         drop_q  <= drop_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      drop_d  = drop_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               owner_d = OWN_D;
               wen_d   = d_req_wen;
               addr_d  = d_req_addr;
               wdata_d = d_req_wdata;
               wmask_d = d_req_wmask;
               state_d = ISSUE;
            end else if (grant_i) begin
               owner_d = OWN_I;
               wen_d   = 1'b0;
               addr_d  = i_req_addr;
               wdata_d = '0;
               wmask_d = '0;
               state_d = ISSUE;
            end
         end
         // A flushed fetch still completes its handshake; only the reply is dropped.
         ISSUE: begin
            if (flush_own)   drop_d  = 1'b1;
            if (m_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (resp_hit) begin
               drop_d  = 1'b0;
               state_d = IDLE;
            end else if (flush_own) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      i_req_ready  = grant_i;
      d_req_ready  = grant_d;
      m_req_valid  = (state_q == ISSUE);
      i_resp_valid = 1'b0;
      i_resp_data  = '0;
      d_resp_valid = 1'b0;
      d_resp_data  = '0;
      if (resp_hit) begin
         if (owner_q == OWN_I) begin
            if (!(drop_q || fence_flush)) begin
               i_resp_valid = 1'b1;
               i_resp_data  = m_resp_data;
            end
         end else begin
            d_resp_valid = 1'b1;
            d_resp_data  = wen_q ? '0 : m_resp_data;
         end
      end
   end

   assign m_req_wen   = wen_q;
   assign m_req_addr  = addr_q;
   assign m_req_wdata = wdata_q;
   assign m_req_wmask = wmask_q;

endmodule
